// File: rtl/ov7670_capture.sv
// ov7670_capture: OV7670 RGB565 byte-stream capture into an RGB444 QVGA frame buffer.
// Runs in the camera pixel-clock domain and reports per-frame completion status.
// Optional feature macro: CAPTURE_FREEZE_EN (per-frame write suppression via freeze).
//
// state   | meaning
// WAIT_VS | after reset, waiting for the first VSYNC rising edge
// SYNC    | inside VSYNC pulse, waiting for its falling edge to start a frame
// CAPTURE | frame active: assemble bytes into pixels, write, count lines
module ov7670_capture #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              freeze,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [11:0]       wData,
  output logic              frame_done,
  output logic              frame_ok
);

  localparam int X_W = $clog2(H_ACTIVE + 1);
  localparam int Y_W = $clog2(V_ACTIVE + 2);
  localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] Y_SAT = Y_W'(V_ACTIVE + 1);

  typedef enum logic [1:0] {WAIT_VS, SYNC, CAPTURE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_vsync_d;
  logic              r_href_d;
  logic              r_phase;
  logic              r_short;
  logic [6:0]        r_byte1;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_base;

  logic              w_vs_rise;
  logic              w_vs_fall;
  logic              w_href_fall;
  logic              w_cap_start;
  logic              w_line_close;
  logic              w_in_window;
  logic              w_block_we;
  logic [Y_W-1:0]    w_y_closed;
  logic              w_short_closed;

  assign w_vs_rise   = cam_vsync & ~r_vsync_d;
  assign w_vs_fall   = ~cam_vsync & r_vsync_d;
  assign w_href_fall = ~cam_href & r_href_d;
  assign w_cap_start = (r_state == SYNC) && w_vs_fall;
  assign w_in_window = (r_x < X_MAX) && (r_y < Y_MAX);

  // A line ends on href fall; a fall with no completed pixel is not a line.
  assign w_line_close = (r_state == CAPTURE) && w_href_fall && (r_x != '0);

  // Line/short status as they will be after closing a line on this edge, so
  // a coincident href fall and vsync rise is judged with the line included.
  assign w_y_closed     = (w_line_close && (r_y != Y_SAT)) ? r_y + 1'b1 : r_y;
  assign w_short_closed = r_short | (w_line_close && (r_x != X_MAX));

`ifdef CAPTURE_FREEZE_EN
  logic r_freeze;

  // Latch freeze once per frame, at the start of capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_freeze <= 1'b0;
    else if (w_cap_start) r_freeze <= freeze;
  end

  assign w_block_we = r_freeze;
`else
  logic w_unused;
  assign w_unused   = freeze;
  assign w_block_we = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= WAIT_VS;
    else          r_state <= w_next;
  end

  // Next-state decode from VSYNC edges
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_VS: if (w_vs_rise) w_next = SYNC;
      SYNC:    if (w_vs_fall) w_next = CAPTURE;
      CAPTURE: if (w_vs_rise) w_next = SYNC;
      default: w_next = WAIT_VS;
    endcase
  end

  // Edge history, byte assembly, pixel/line counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync_d  <= 1'b0;
      r_href_d   <= 1'b0;
      r_phase    <= 1'b0;
      r_short    <= 1'b0;
      r_byte1    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_base     <= '0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
    end else begin
      r_vsync_d  <= cam_vsync;
      r_href_d   <= cam_href;
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (w_cap_start) begin
        r_x     <= '0;
        r_y     <= '0;
        r_base  <= '0;
        r_phase <= 1'b0;
        r_short <= 1'b0;
      end else if (r_state == CAPTURE) begin
        if (cam_href) begin
          if (!r_phase) begin
            r_byte1 <= {cam_data[7:4], cam_data[2:0]};
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (w_in_window && !w_block_we) begin
              we    <= 1'b1;
              wAddr <= r_base + ADDR_W'(r_x);
              wData <= {r_byte1[6:3], r_byte1[2:0], cam_data[7], cam_data[4:1]};
            end
            if (r_x != X_MAX) r_x <= r_x + 1'b1;
          end
        end else if (w_href_fall) begin
          r_x     <= '0;
          r_phase <= 1'b0;
          if (w_line_close) begin
            if (r_y != Y_SAT) begin
              r_y    <= r_y + 1'b1;
              r_base <= r_base + ADDR_W'(H_ACTIVE);
            end
            if (r_x != X_MAX) r_short <= 1'b1;
          end
        end
        if (w_vs_rise) begin
          frame_done <= 1'b1;
          frame_ok   <= (w_y_closed == Y_MAX) && !w_short_closed;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: directed bench for ov7670_capture on a reduced frame size.
module tb_ov7670_capture;

  localparam int H  = 40;
  localparam int V  = 30;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic          freeze = 1'b0;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [11:0]   wData;
  logic          frame_done;
  logic          frame_ok;

  int checks = 0;
  int errors = 0;

  int          q_addr[$];
  logic [11:0] q_data[$];
  int          n_done = 0;
  logic        last_ok = 1'b0;
  int          e_addr[$];
  logic [11:0] e_data[$];

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .freeze(freeze), .we(we), .wAddr(wAddr), .wData(wData),
    .frame_done(frame_done), .frame_ok(frame_ok)
  );

  always #5 clk = ~clk;

  // Observe writes and frame status between active edges
  always @(negedge clk) begin
    if (we === 1'b1) begin
      q_addr.push_back(int'(wAddr));
      q_data.push_back(wData);
    end
    if (frame_done === 1'b1) begin
      n_done++;
      last_ok = frame_ok;
    end
  end

  function automatic logic [7:0] byte_at(input int l, input int b);
    return 8'((l * 37 + b * 11 + 5) % 256);
  endfunction

  function automatic logic [11:0] rgb(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[7:4], b1[2:0], b2[7], b2[4:1]};
  endfunction

  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    q_addr.delete();
    q_data.delete();
    n_done = 0;
  endtask

  // Expected writes: line l occupies l*H.., only first H pixels of first V lines
  task automatic build_expected(input int n_lines, input int n_bytes,
                                input int short_line, input int short_bytes);
    e_addr.delete();
    e_data.delete();
    for (int l = 0; l < n_lines && l < V; l++) begin
      int np;
      np = ((l == short_line) ? short_bytes : n_bytes) / 2;
      for (int p = 0; p < np && p < H; p++) begin
        e_addr.push_back(l * H + p);
        e_data.push_back(rgb(byte_at(l, 2 * p), byte_at(l, 2 * p + 1)));
      end
    end
  endtask

  // VSYNC pulse, lines, then VSYNC rise (left high)
  task automatic run_frame(input int n_lines, input int n_bytes, input int short_line,
                           input int short_bytes, input bit merge_end);
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < n_lines; l++) begin
      int nb;
      nb = (l == short_line) ? short_bytes : n_bytes;
      for (int b = 0; b < nb; b++) cyc(1'b0, 1'b1, byte_at(l, b));
      if (!(merge_end && l == n_lines - 1)) repeat (4) cyc(1'b0, 1'b0, 8'h00);
    end
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (we !== 1'b0 || wAddr !== '0 || wData !== '0 || frame_done !== 1'b0 || frame_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_init got we=%b wAddr=%0d wData=%h fd=%b ok=%b exp all 0",
               we, wAddr, wData, frame_done, frame_ok);
    end
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    for (int b = 0; b < 6; b++) cyc(1'b0, 1'b1, byte_at(0, b));
    checks++;
    if (we !== 1'b1 || wAddr !== AW'(2)) begin
      errors++;
      $display("FAIL reset_prewrite got we=%b wAddr=%0d exp we=1 wAddr=2", we, wAddr);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (we !== 1'b0 || wAddr !== '0 || wData !== '0 || frame_done !== 1'b0 || frame_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got we=%b wAddr=%0d wData=%h fd=%b ok=%b exp all 0",
               we, wAddr, wData, frame_done, frame_ok);
    end
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 8'hAA);
    #2 reset_n = 1'b1;
    clear_obs();
    for (int b = 0; b < 10; b++) cyc(1'b0, 1'b1, 8'h5A);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    for (int b = 0; b < 6; b++) cyc(1'b1, 1'b1, 8'hC3);
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    checks++;
    if (q_addr.size() !== 0 || n_done !== 0) begin
      errors++;
      $display("FAIL reset_no_write got writes=%0d done=%0d exp 0 and 0", q_addr.size(), n_done);
    end
  endtask

  task automatic test_single_pixel();
    clear_obs();
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hF8);
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL single_byte1 got we=%b exp 0", we);
    end
    cyc(1'b0, 1'b1, 8'h1F);
    checks++;
    if (we !== 1'b1 || wAddr !== '0 || wData !== 12'hF0F) begin
      errors++;
      $display("FAIL single_pixel got we=%b wAddr=%0d wData=%h exp 1 0 f0f", we, wAddr, wData);
    end
    cyc(1'b0, 1'b0, 8'h00);
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL single_we_len got we=%b exp 0", we);
    end
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    checks++;
    if (q_addr.size() !== 1 || n_done !== 1 || last_ok !== 1'b0) begin
      errors++;
      $display("FAIL single_frame got writes=%0d done=%0d ok=%b exp 1 1 0",
               q_addr.size(), n_done, last_ok);
    end
  endtask

  task automatic test_full_frame(input bit merge_end);
    int bad;
    clear_obs();
    build_expected(V, 2 * H, -1, 0);
    run_frame(V, 2 * H, -1, 0, merge_end);
    checks++;
    if (q_addr.size() !== e_addr.size()) begin
      errors++;
      $display("FAIL full_count merge=%0d got %0d exp %0d", merge_end, q_addr.size(), e_addr.size());
    end
    bad = 0;
    for (int i = 0; i < e_addr.size(); i++)
      if (i >= q_addr.size() || q_addr[i] != e_addr[i] || q_data[i] !== e_data[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_content merge=%0d got %0d bad writes exp 0", merge_end, bad);
    end
    checks++;
    if (n_done !== 1 || last_ok !== 1'b1) begin
      errors++;
      $display("FAIL full_status merge=%0d got done=%0d ok=%b exp 1 1", merge_end, n_done, last_ok);
    end
  endtask

  task automatic test_over_long();
    int bad;
    clear_obs();
    build_expected(V + 10, 2 * H + 60, -1, 0);
    run_frame(V + 10, 2 * H + 60, -1, 0, 1'b0);
    checks++;
    if (q_addr.size() !== H * V) begin
      errors++;
      $display("FAIL long_count got %0d exp %0d", q_addr.size(), H * V);
    end
    checks++;
    if (q_addr.size() == 0 || q_addr[q_addr.size() - 1] !== H * V - 1) begin
      errors++;
      $display("FAIL long_last_addr got %0d exp %0d",
               (q_addr.size() == 0) ? -1 : q_addr[q_addr.size() - 1], H * V - 1);
    end
    bad = 0;
    for (int i = 0; i < e_addr.size(); i++)
      if (i >= q_addr.size() || q_addr[i] != e_addr[i] || q_data[i] !== e_data[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL long_content got %0d bad writes exp 0", bad);
    end
    checks++;
    if (n_done !== 1 || last_ok !== 1'b0) begin
      errors++;
      $display("FAIL long_status got done=%0d ok=%b exp 1 0", n_done, last_ok);
    end
  endtask

  task automatic test_short_line();
    int bad;
    clear_obs();
    build_expected(V, 2 * H, 5, 2 * H - 1);
    run_frame(V, 2 * H, 5, 2 * H - 1, 1'b0);
    checks++;
    if (q_addr.size() !== H * V - 1) begin
      errors++;
      $display("FAIL short_count got %0d exp %0d", q_addr.size(), H * V - 1);
    end
    checks++;
    if (q_addr.size() < 6 * H || q_addr[6 * H - 1] !== 6 * H) begin
      errors++;
      $display("FAIL short_line6_base got %0d exp %0d",
               (q_addr.size() < 6 * H) ? -1 : q_addr[6 * H - 1], 6 * H);
    end
    bad = 0;
    for (int i = 0; i < e_addr.size(); i++)
      if (i >= q_addr.size() || q_addr[i] != e_addr[i] || q_data[i] !== e_data[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL short_content got %0d bad writes exp 0", bad);
    end
    checks++;
    if (n_done !== 1 || last_ok !== 1'b0) begin
      errors++;
      $display("FAIL short_status got done=%0d ok=%b exp 1 0", n_done, last_ok);
    end
  endtask

  task automatic test_freeze();
    clear_obs();
    freeze = 1'b1;
    run_frame(V, 2 * H, -1, 0, 1'b0);
    freeze = 1'b0;
`ifdef CAPTURE_FREEZE_EN
    checks++;
    if (q_addr.size() !== 0) begin
      errors++;
      $display("FAIL freeze_writes got %0d exp 0", q_addr.size());
    end
`else
    checks++;
    if (q_addr.size() !== H * V) begin
      errors++;
      $display("FAIL freeze_ignored_writes got %0d exp %0d", q_addr.size(), H * V);
    end
`endif
    checks++;
    if (n_done !== 1 || last_ok !== 1'b1) begin
      errors++;
      $display("FAIL freeze_status got done=%0d ok=%b exp 1 1", n_done, last_ok);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_full_frame(1'b0);
    test_full_frame(1'b1);
    test_over_long();
    test_short_line();
    test_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
